private_key_loader: RTL and testbench

Consumes the 256-bit `private_key` / single-cycle `private_key_valid` stream from the private key generator and delivers each key to downstream crypto cores as a sequence of 32-bit words over a valid/ready handshake. A one-deep pending slot absorbs a key that arrives while a transfer is still in progress. Overrun events and delivered keys are counted. The block sits between key generation and the ECC/signature datapath, on the key clock domain.

---
 rtl/private_key_pkg.sv | 14 +
 rtl/private_key_slot.sv | 42 ++++
 rtl/private_key_loader.sv | 121 ++++++++++++
 tb/tb_private_key_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/private_key_pkg.sv
// Shared constants and state type for the private key generator and loader.
package private_key_pkg;

  localparam int KEY_W     = 256;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = KEY_W / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } key_ld_state_t;

endpackage

// File: rtl/private_key_slot.sv
// Key-wide holding register with load enable and a full flag.
// Load takes priority over clear so a refill on the drain cycle keeps the slot full.
module private_key_slot #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule

// File: rtl/private_key_loader.sv
// Streams each 256-bit private key out as 32-bit words, MSW first, over valid/ready.
// A one-deep pending slot holds the next key; overwriting it counts as an overrun.
module private_key_loader
  import private_key_pkg::*;
(
  input  logic              key_clk,
  input  logic              key_reset,
  input  logic [KEY_W-1:0]  private_key,
  input  logic              private_key_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic [IDX_W-1:0]  word_index,
  output logic              busy,
  output logic [15:0]       keys_sent,
  output logic [7:0]        overrun_count
);

  key_ld_state_t     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [KEY_W-1:0]  shadow_q, shadow_d;
  logic [15:0]       keys_sent_q, keys_sent_d;
  logic [7:0]        overrun_q, overrun_d;

  logic              pend_load, pend_clear, pend_full;
  logic [KEY_W-1:0]  pend_key;

  logic              in_send, handshake, last_hs;
  logic [WORD_W-1:0] words [NUM_WORDS];

  private_key_slot #(.W(KEY_W)) u_pend (
    .clk   (key_clk),
    .rst   (key_reset),
    .load  (pend_load),
    .clear (pend_clear),
    .d     (private_key),
    .q     (pend_key),
    .full  (pend_full)
  );

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
    assign words[gi] = shadow_q[KEY_W-1-WORD_W*gi -: WORD_W];
  end

  assign in_send   = (state_q == SEND);
  assign word_valid = in_send;
  assign word_last  = in_send && (idx_q == IDX_W'(NUM_WORDS - 1));
  assign word_index = idx_q;
  assign word_data  = in_send ? words[idx_q] : '0;
  assign busy       = in_send | pend_full;
  assign handshake  = in_send & word_ready;
  assign last_hs    = handshake & word_last;

  assign keys_sent     = keys_sent_q;
  assign overrun_count = overrun_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    keys_sent_d = keys_sent_q;
    overrun_d   = overrun_q;
    pend_load   = 1'b0;
    pend_clear  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (private_key_valid) begin
          shadow_d = private_key;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (last_hs) begin
          keys_sent_d = keys_sent_q + 16'd1;
          idx_d       = '0;
          if (pend_full) begin
            // Pending key becomes active; a simultaneous new key refills the slot.
            shadow_d   = pend_key;
            pend_clear = 1'b1;
            pend_load  = private_key_valid;
          end else if (private_key_valid) begin
            shadow_d = private_key;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (private_key_valid) begin
            pend_load = 1'b1;
            if (pend_full && overrun_q != 8'hFF) begin
              overrun_d = overrun_q + 8'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge key_clk or posedge key_reset) begin
    if (key_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      keys_sent_q <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      keys_sent_q <= keys_sent_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_private_key_loader.sv
// Directed bench for private_key_loader: key-queue scoreboard checked every cycle plus literal checks.
module tb_private_key_loader;
  import private_key_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [KEY_W-1:0]  private_key = '0;
  logic              private_key_valid = 1'b0;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic              word_last;
  logic [IDX_W-1:0]  word_index;
  logic              busy;
  logic [15:0]       keys_sent;
  logic [7:0]        overrun_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: queue of keys still owed downstream (front = active), position in front key.
  logic [KEY_W-1:0]  kq[$];
  int                wpos = 0;
  int                m_sent = 0;
  int                m_ovr = 0;
  logic [WORD_W-1:0] dut_log[$];

  localparam logic [KEY_W-1:0] K0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [KEY_W-1:0] KB = ~K0;
  localparam logic [KEY_W-1:0] KC = K0 ^ {8{32'hdeadbeef}};
  localparam logic [KEY_W-1:0] KE = {K0[127:0], K0[255:128]};

  private_key_loader dut (
    .key_clk           (clk),
    .key_reset         (rst),
    .private_key       (private_key),
    .private_key_valid (private_key_valid),
    .word_data         (word_data),
    .word_valid        (word_valid),
    .word_ready        (word_ready),
    .word_last         (word_last),
    .word_index        (word_index),
    .busy              (busy),
    .keys_sent         (keys_sent),
    .overrun_count     (overrun_count)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] mword(input logic [KEY_W-1:0] k, input int i);
    logic [KEY_W-1:0] t;
    t = k >> (WORD_W * (NUM_WORDS - 1 - i));
    return t[WORD_W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model update on every rising edge (or immediately on reset).
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        kq.delete();
        wpos   = 0;
        m_sent = 0;
        m_ovr  = 0;
      end else begin
        if (kq.size() > 0 && word_ready) begin
          if (wpos == NUM_WORDS - 1) begin
            void'(kq.pop_front());
            wpos   = 0;
            m_sent = (m_sent + 1) % 65536;
          end else begin
            wpos++;
          end
        end
        if (private_key_valid) begin
          if (kq.size() < 2) begin
            kq.push_back(private_key);
          end else begin
            kq[1] = private_key;
            if (m_ovr < 255) m_ovr++;
          end
        end
      end
    end
  end

  // Compare process: every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("word_valid", KEY_W'(word_valid), KEY_W'(kq.size() > 0));
        chk("busy", KEY_W'(busy), KEY_W'(kq.size() > 0));
        if (kq.size() > 0) begin
          chk("word_data", KEY_W'(word_data), KEY_W'(mword(kq[0], wpos)));
          chk("word_index", KEY_W'(word_index), KEY_W'(wpos));
          chk("word_last", KEY_W'(word_last), KEY_W'(wpos == NUM_WORDS - 1));
        end
        chk("keys_sent", KEY_W'(keys_sent), KEY_W'(m_sent));
        chk("overrun_count", KEY_W'(overrun_count), KEY_W'(m_ovr));
        if (word_valid && word_ready) dut_log.push_back(word_data);
      end
    end
  end

  task automatic strobe(input logic [KEY_W-1:0] k);
    private_key       = k;
    private_key_valid = 1'b1;
    @(posedge clk);
    #2;
    private_key_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string nm, input logic [KEY_W-1:0] k0,
                           input logic [KEY_W-1:0] k1, input int nkeys);
    chk({nm, "_count"}, KEY_W'(dut_log.size()), KEY_W'(nkeys * NUM_WORDS));
    for (int i = 0; i < dut_log.size() && i < nkeys * NUM_WORDS; i++) begin
      chk(nm, KEY_W'(dut_log[i]), KEY_W'(mword((i < NUM_WORDS) ? k0 : k1, i % NUM_WORDS)));
    end
    $display("%s: %0d words delivered", nm, dut_log.size());
  endtask

  initial begin
    bit found;

    // Reset state.
    #1;
    chk("rst_valid", KEY_W'(word_valid), '0);
    chk("rst_data", KEY_W'(word_data), '0);
    chk("rst_busy", KEY_W'(busy), '0);
    chk("rst_keys", KEY_W'(keys_sent), '0);
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // 1: single key, ready held high; literal word values and latency.
    word_ready = 1'b1;
    dut_log.delete();
    strobe(K0);
    @(negedge clk);
    chk("t1_first_valid", KEY_W'(word_valid), KEY_W'(1'b1));
    chk("t1_first_word", KEY_W'(word_data), KEY_W'(32'h00010203));
    repeat (7) @(negedge clk);
    chk("t1_last_word", KEY_W'(word_data), KEY_W'(32'h1c1d1e1f));
    chk("t1_last_flag", KEY_W'(word_last), KEY_W'(1'b1));
    @(negedge clk);
    chk("t1_idle_valid", KEY_W'(word_valid), '0);
    chk("t1_idle_busy", KEY_W'(busy), '0);
    chk("t1_keys", KEY_W'(keys_sent), KEY_W'(16'd1));
    check_log("t1_log", K0, K0, 1);
    cycles(2);

    // 2: random stalls.
    dut_log.delete();
    strobe(K0);
    for (int i = 0; i < 40; i++) begin
      word_ready = (i < 4) ? ((i == 0) || (i == 3)) : ($urandom_range(0, 2) != 0);
      cycles(1);
    end
    word_ready = 1'b1;
    cycles(12);
    check_log("t2_log", K0, K0, 1);
    chk("t2_keys", KEY_W'(keys_sent), KEY_W'(16'd2));

    // 3: second key strobed mid-transfer streams with no bubble.
    dut_log.delete();
    strobe(K0);
    cycles(2);
    strobe(KB);
    cycles(20);
    check_log("t3_log", K0, KB, 2);
    chk("t3_ovr", KEY_W'(overrun_count), '0);
    chk("t3_keys", KEY_W'(keys_sent), KEY_W'(16'd4));

    // 4: A active, B then C while stalled -> C replaces B.
    dut_log.delete();
    strobe(K0);
    word_ready = 1'b0;
    strobe(KB);
    strobe(KC);
    cycles(3);
    @(negedge clk);
    chk("t4_ovr", KEY_W'(overrun_count), KEY_W'(8'd1));
    chk("t4_busy", KEY_W'(busy), KEY_W'(1'b1));
    cycles(1);
    word_ready = 1'b1;
    cycles(25);
    check_log("t4_log", K0, KC, 2);
    chk("t4_keys", KEY_W'(keys_sent), KEY_W'(16'd6));

    // 5: strobe exactly on the last-word handshake with pend empty.
    dut_log.delete();
    strobe(K0);
    repeat (7) @(posedge clk);
    #2;
    strobe(KB);
    @(negedge clk);
    chk("t5_valid", KEY_W'(word_valid), KEY_W'(1'b1));
    chk("t5_index", KEY_W'(word_index), '0);
    chk("t5_word0", KEY_W'(word_data), KEY_W'(32'hfffefdfc));
    chk("t5_keys_mid", KEY_W'(keys_sent), KEY_W'(16'd7));
    cycles(12);
    check_log("t5_log", K0, KB, 2);
    chk("t5_keys", KEY_W'(keys_sent), KEY_W'(16'd8));

    // 6: asynchronous reset at word 5 with a pending key.
    strobe(K0);
    strobe(KB);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (word_index == IDX_W'(5)) found = 1'b1;
    end
    chk("t6_reach_word5", KEY_W'(found), KEY_W'(1'b1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", KEY_W'(word_valid), '0);
    chk("t6_rst_data", KEY_W'(word_data), '0);
    chk("t6_rst_index", KEY_W'(word_index), '0);
    chk("t6_rst_last", KEY_W'(word_last), '0);
    chk("t6_rst_busy", KEY_W'(busy), '0);
    chk("t6_rst_keys", KEY_W'(keys_sent), '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    dut_log.delete();
    cycles(12);
    chk("t6_no_words", KEY_W'(dut_log.size()), '0);
    strobe(KE);
    cycles(12);
    check_log("t6_log", KE, KE, 1);
    chk("t6_keys", KEY_W'(keys_sent), KEY_W'(16'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
